// File: rtl/sonar_bus_pkg.sv
// Shared definitions for the SonarOnChip register-bus initiator:
// bus geometry, register map and the initiator FSM state type.
package sonar_bus_pkg;

  localparam int BUS_WIDTH  = 16;
  localparam int ADDR_WIDTH = 4;

  localparam logic [3:0] CONTROL   = 4'd0;
  localparam logic [3:0] A0        = 4'd1;
  localparam logic [3:0] A1        = 4'd2;
  localparam logic [3:0] A2        = 4'd3;
  localparam logic [3:0] B1        = 4'd4;
  localparam logic [3:0] B2        = 4'd5;
  localparam logic [3:0] AMP       = 4'd6;
  localparam logic [3:0] THRESHOLD = 4'd7;
  localparam logic [3:0] TIMER     = 4'd8;
  localparam logic [3:0] PCM       = 4'd9;
  localparam logic [3:0] PCM_LOAD  = 4'd10;
  localparam logic [3:0] FB0       = 4'd11;
  localparam logic [3:0] FB1       = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sonar_cmd_fifo.sv
// Command queue for the bus initiator: synchronous FIFO with full/empty
// flags, a combinational head read and an active-low synchronous reset.
module sonar_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sonar_bus_master.sv
// Register-bus initiator: queues commands, issues each as a single-cycle
// m_valid_o pulse, waits for ack with timeout, returns one response each.
module sonar_bus_master import sonar_bus_pkg::*; #(
  parameter int BUS_WIDTH  = sonar_bus_pkg::BUS_WIDTH,
  parameter int ADDR_WIDTH = sonar_bus_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_dat_i,
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_we_o,
  output logic                  busy_o,
  output logic                  m_valid_o,
  output logic [ADDR_WIDTH-1:0] m_adr_o,
  output logic [BUS_WIDTH-1:0]  m_dat_o,
  output logic                  m_strb_o,
  input  logic                  m_ack_i,
  input  logic [BUS_WIDTH-1:0]  m_dat_i
);

  localparam int FW = 1 + ADDR_WIDTH + BUS_WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            fifo_full, fifo_empty;
  logic            push, pop, ack_take, tmo;
  logic [FW-1:0]   head;

  assign cmd_ready_o = wb_rst_i && !fifo_full;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign busy_o      = (state != IDLE) || !fifo_empty;

  sonar_cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .push  (push),
    .wdata ({cmd_we_i, cmd_adr_i, cmd_dat_i}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // next-state: acks outside WAIT are never looked at, so strays vanish
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    ack_take = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (m_ack_i) begin
          ack_take = 1'b1;
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // bus-side and response registers; m_* hold between transactions
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      m_valid_o   <= 1'b0;
      m_strb_o    <= 1'b0;
      m_adr_o     <= '0;
      m_dat_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      rsp_we_o    <= 1'b0;
    end else begin
      m_valid_o   <= pop;
      rsp_valid_o <= ack_take || tmo;
      if (pop) {m_strb_o, m_adr_o, m_dat_o} <= head;
      if (ack_take) begin
        rsp_dat_o <= m_dat_i;
        rsp_err_o <= 1'b0;
        rsp_we_o  <= m_strb_o;
      end else if (tmo) begin
        rsp_dat_o <= '0;
        rsp_err_o <= 1'b1;
        rsp_we_o  <= m_strb_o;
      end
    end
  end

endmodule

// File: tb/tb_sonar_bus_master.sv
// Self-checking bench: cycle-level behavioural model of command timing and
// responses, a register-file responder, directed cases then random traffic.
`timescale 1ns/1ps
module tb_sonar_bus_master;
  import sonar_bus_pkg::*;

  localparam int BW = 16, AW = 4, DEPTH = 4, TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr, m_adr;
  logic [BW-1:0] cmd_dat, rsp_dat, m_dat_o, m_dat_i;
  logic rsp_valid, rsp_err, rsp_we, busy, m_valid, m_strb, m_ack;

  sonar_bus_master #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .rsp_we_o(rsp_we),
    .busy_o(busy), .m_valid_o(m_valid), .m_adr_o(m_adr), .m_dat_o(m_dat_o),
    .m_strb_o(m_strb), .m_ack_i(m_ack), .m_dat_i(m_dat_i)
  );

  typedef struct { logic we; logic [3:0] adr; logic [15:0] dat; int w; int acc; } cmd_t;
  typedef struct { logic [15:0] dat; logic err; logic we; int cyc; } rsp_t;

  cmd_t sq[$];
  cmd_t cmdq[$];
  rsp_t obs[$];
  cmd_t cur;
  int compared = 0, mismatched = 0;
  int cyc = 0;
  bit inflight = 0, rst_req = 1, stray_en = 0, pend = 0, track = 0, ready_low_seen = 0;
  int due, free_cyc = 0, ack_cyc, vcount = 0, last_acc = 0;
  logic [15:0] exp_dat, ack_dat;
  logic exp_err;
  logic [15:0] mdl_mem [16];
  logic [15:0] slv_mem [16];
  logic [3:0] vlast_adr;
  logic vlast_strb;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic enq(input logic we, input logic [3:0] adr, input logic [15:0] dat, input int w);
    cmd_t c;
    c.we = we; c.adr = adr; c.dat = dat; c.w = w; c.acc = 0;
    sq.push_back(c);
  endtask

  // one clock: advance model, compare, run responder, drive next inputs
  task automatic step();
    bit mv_e, rv_e, rst_edge;
    rsp_t o;
    @(negedge clk);
    rst_edge = !rst_n;
    mv_e = 0; rv_e = 0;
    if (rst_edge) begin
      cmdq.delete(); inflight = 0; free_cyc = cyc;
    end
    if (!rst_edge && !inflight && cmdq.size() > 0 && cyc >= max2(cmdq[0].acc, free_cyc) + 1) begin
      cur = cmdq.pop_front(); inflight = 1; mv_e = 1;
      if (cur.w <= TMO - 1) begin
        due = cyc + 2 + cur.w; exp_dat = mdl_mem[cur.adr]; exp_err = 1'b0;
      end else begin
        due = cyc + 1 + TMO; exp_dat = 16'h0000; exp_err = 1'b1;
      end
      if (cur.we) mdl_mem[cur.adr] = cur.dat;
    end
    if (inflight && cyc == due) begin
      rv_e = 1; inflight = 0; free_cyc = cyc;
    end
    chk("m_valid", 32'(m_valid), 32'(mv_e));
    chk("rsp_valid", 32'(rsp_valid), 32'(rv_e));
    chk("busy", 32'(busy), 32'(cmdq.size() > 0 || inflight));
    chk("cmd_ready", 32'(cmd_ready), 32'(rst_n && cmdq.size() < DEPTH));
    if (mv_e && m_valid) begin
      chk("m_adr", 32'(m_adr), 32'(cur.adr));
      chk("m_strb", 32'(m_strb), 32'(cur.we));
      if (cur.we) chk("m_dat", 32'(m_dat_o), 32'(cur.dat));
    end
    if (rv_e && rsp_valid) begin
      chk("rsp_dat", 32'(rsp_dat), 32'(exp_dat));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_we", 32'(rsp_we), 32'(cur.we));
    end
    if (rst_edge)
      chk("reset_zero", 32'({m_adr, m_dat_o, m_strb, rsp_dat, rsp_err, rsp_we}), 32'd0);
    if (m_valid) begin
      vcount++; vlast_adr = m_adr; vlast_strb = m_strb;
    end
    if (rsp_valid) begin
      o.dat = rsp_dat; o.err = rsp_err; o.we = rsp_we; o.cyc = cyc;
      obs.push_back(o);
    end
    if (track && sq.size() > 0 && !cmd_ready) ready_low_seen = 1;
    // responder: register file returning prior contents
    if (m_valid) begin
      pend = 1; ack_cyc = cyc + 1 + cur.w; ack_dat = slv_mem[m_adr];
      if (m_strb) slv_mem[m_adr] = m_dat_o;
    end
    if (pend && cyc == ack_cyc) begin
      m_ack = 1'b1; m_dat_i = ack_dat; pend = 0;
    end else if (!pend && stray_en && $urandom_range(0, 7) == 0) begin
      m_ack = 1'b1; m_dat_i = 16'($urandom);
    end else begin
      m_ack = 1'b0; m_dat_i = 16'($urandom);
    end
    rst_n = rst_req ? 1'b0 : 1'b1;
    if (sq.size() > 0) begin
      cmd_valid = 1'b1; cmd_we = sq[0].we; cmd_adr = sq[0].adr; cmd_dat = sq[0].dat;
      if (rst_n && cmdq.size() < DEPTH) begin
        cmd_t c;
        c = sq.pop_front(); c.acc = cyc + 1; last_acc = c.acc;
        cmdq.push_back(c);
      end
    end else begin
      cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = 4'($urandom); cmd_dat = 16'($urandom);
    end
  endtask

  task automatic do_one(input logic we, input logic [3:0] adr, input logic [15:0] dat, input int w,
                        output rsp_t r, output int lat, output int vd);
    int n0, v0, k;
    n0 = obs.size(); v0 = vcount; k = 0;
    enq(we, adr, dat, w);
    while (obs.size() == n0 && k < 60) begin step(); k++; end
    chk("rsp_arrives", 32'(obs.size() > n0), 32'd1);
    if (obs.size() > n0) begin r = obs[obs.size() - 1]; lat = r.cyc - last_acc; end
    else begin r.dat = 16'h0; r.err = 1'b0; r.we = 1'b0; r.cyc = 0; lat = -1; end
    vd = vcount - v0;
  endtask

  initial begin
    rsp_t r;
    int lat, vd, n0, v0, k, gen, wr;
    logic [15:0] exp5 [5];
    logic [3:0] adr5 [5];
    exp5 = '{16'h4444, 16'h5555, 16'h6666, 16'hBBBB, 16'hCCCC};
    adr5 = '{B1, B2, AMP, FB0, FB1};
    for (int i = 0; i < 16; i++) begin
      mdl_mem[i] = 16'(i * 16'h1111); slv_mem[i] = 16'(i * 16'h1111);
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    m_ack = 1'b0; m_dat_i = '0;
    repeat (3) step();
    rst_req = 0;
    repeat (2) step();

    // write A0 then read it back, zero-wait responder
    do_one(1'b1, A0, 16'h1234, 0, r, lat, vd);
    chk("wr_lat", 32'(lat), 32'd3); chk("wr_pulses", 32'(vd), 32'd1);
    chk("wr_strb", 32'(vlast_strb), 32'd1); chk("wr_adr", 32'(vlast_adr), 32'd1);
    chk("wr_prior", 32'(r.dat), 32'h1111);
    do_one(1'b0, A0, 16'h0000, 0, r, lat, vd);
    chk("rd_dat", 32'(r.dat), 32'h1234); chk("rd_err", 32'(r.err), 32'd0);
    chk("rd_lat", 32'(lat), 32'd3); chk("rd_pulses", 32'(vd), 32'd1);
    chk("rd_strb", 32'(vlast_strb), 32'd0); chk("rd_adr", 32'(vlast_adr), 32'd1);

    // write PCM with all ones
    do_one(1'b1, PCM, 16'hFFFF, 0, r, lat, vd);
    chk("pcm_dat", 32'(r.dat), 32'h9999); chk("pcm_we", 32'(r.we), 32'd1);
    chk("pcm_err", 32'(r.err), 32'd0); chk("pcm_pulses", 32'(vd), 32'd1);

    // slow responder: three wait cycles
    do_one(1'b1, TIMER, 16'hBEEF, 0, r, lat, vd);
    do_one(1'b0, TIMER, 16'h0000, 3, r, lat, vd);
    chk("slow_dat", 32'(r.dat), 32'hBEEF); chk("slow_lat", 32'(lat), 32'd6);
    chk("slow_pulses", 32'(vd), 32'd1);

    // timeout boundary: ack one cycle too late, then just in time
    do_one(1'b0, THRESHOLD, 16'h0000, 15, r, lat, vd);
    chk("tmo_err", 32'(r.err), 32'd1); chk("tmo_dat", 32'(r.dat), 32'd0);
    chk("tmo_lat", 32'(lat), 32'd17);
    n0 = obs.size();
    repeat (5) step();
    chk("no_extra_rsp", 32'(obs.size() - n0), 32'd0);
    do_one(1'b0, THRESHOLD, 16'h0000, 14, r, lat, vd);
    chk("late_ok_err", 32'(r.err), 32'd0); chk("late_ok_dat", 32'(r.dat), 32'h7777);
    chk("late_ok_lat", 32'(lat), 32'd17);

    // queue fill: one long transaction, then five back-to-back reads
    track = 1; ready_low_seen = 0; n0 = obs.size(); v0 = vcount; k = 0;
    enq(1'b0, CONTROL, 16'h0000, 8);
    while (vcount == v0 && k < 20) begin step(); k++; end
    for (int i = 0; i < 5; i++) enq(1'b0, adr5[i], 16'h0000, 0);
    k = 0;
    while (obs.size() < n0 + 6 && k < 150) begin step(); k++; end
    track = 0;
    chk("fill_count", 32'(obs.size() - n0), 32'd6);
    chk("fill_ready_low", 32'(ready_low_seen), 32'd1);
    for (int i = 0; i < 5; i++)
      if (obs.size() > n0 + 1 + i) chk("fill_order", 32'(obs[n0 + 1 + i].dat), 32'(exp5[i]));

    // reset while waiting with two queued, responder acks after reset
    n0 = obs.size(); v0 = vcount; k = 0;
    for (int i = 0; i < 3; i++) enq(1'b0, 4'(FB0 + i), 16'h0000, 12);
    while (vcount == v0 && k < 20) begin step(); k++; end
    repeat (3) step();
    rst_req = 1; repeat (3) step();
    rst_req = 0; repeat (20) step();
    chk("rst_no_rsp", 32'(obs.size() - n0), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // random traffic with stray acks
    stray_en = 1; gen = 0;
    while (gen < 250) begin
      if (sq.size() < 3 && $urandom_range(0, 2) != 0) begin
        wr = int'($urandom_range(0, 9));
        enq(1'($urandom), 4'($urandom), 16'($urandom),
            (wr < 7) ? int'($urandom_range(0, 3)) :
            (wr < 9) ? int'($urandom_range(4, 12)) : int'($urandom_range(13, 16)));
        gen++;
      end
      step();
    end
    k = 0;
    while ((sq.size() > 0 || cmdq.size() > 0 || inflight || pend) && k < 2000) begin step(); k++; end
    chk("drain", 32'(sq.size() == 0 && cmdq.size() == 0 && !inflight), 32'd1);
    stray_en = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
